i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, giving the sample width read from the upstream FIFO.
REQ-002 SHALL have parameter SLOT_WIDTH, default 16, giving bits per channel slot; SLOT_WIDTH >= DATA_WIDTH is required.
REQ-003 SHALL have parameter BCLK_DIV, default 4, giving clk cycles per bclk half-period; BCLK_DIV >= 2 is required.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, which runs the serializer while high.
REQ-007 SHALL have port fifo_empty, input, 1, the FIFO read-side empty flag.
REQ-008 SHALL have port fifo_data, input, DATA_WIDTH, the FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_rd_en, output, 1, a registered one-cycle FIFO pop strobe.
REQ-010 SHALL have ports i2s_bclk, i2s_lrclk and i2s_sdata, each output, 1, all registered: bit clock, word select (0 = left) and serial data.
REQ-011 SHALL have port underrun, output, 1, a one-cycle pulse on each slot loaded without a sample.
REQ-012 SHALL have port underrun_cnt, output, 16, a saturating count of underrun pulses.

Function
REQ-013 SHALL count clk cycles 0..BCLK_DIV-1 in a divider while en=1 and toggle i2s_bclk when the count equals BCLK_DIV-1.
REQ-014 SHALL treat each i2s_bclk 1->0 toggle as the bit event and advance bit_cnt (0..2*SLOT_WIDTH-1, wrapping to 0) on it.
REQ-015 SHALL drive i2s_lrclk=1 exactly while bit_cnt is in SLOT_WIDTH..2*SLOT_WIDTH-1 and 0 otherwise, so word select changes one bit before each MSB.
REQ-016 SHALL load a SLOT_WIDTH shift register on the bit event that sets bit_cnt to 1 (left) and to SLOT_WIDTH+1 (right), with the sample MSB-aligned and the low SLOT_WIDTH-DATA_WIDTH bits zero.
REQ-017 SHALL present the shift register MSB on i2s_sdata and shift left by one, filling with 0, on every other bit event; the final right-slot bit therefore appears while bit_cnt=0.
REQ-018 SHALL hold one sample in a shadow register with a valid flag, with the shift-register load taking the shadow value and clearing the flag.
REQ-019 SHALL, when a load finds the shadow invalid, load all zeros, pulse underrun for one cycle and increment underrun_cnt, saturating at 16'hFFFF.
REQ-020 SHALL run a fetch FSM with states IDLE, POP and CAPTURE.
REQ-021 SHALL transition IDLE->POP when the shadow is invalid and fifo_empty=0 and en=1, asserting fifo_rd_en during POP.
REQ-022 SHALL transition POP->CAPTURE unconditionally, then CAPTURE->IDLE while writing fifo_data into the shadow and setting the flag.
REQ-023 SHALL assert fifo_rd_en for exactly one cycle per pop and never while fifo_empty=1 was sampled in IDLE.
REQ-024 SHALL give a slot load that coincides with CAPTURE the invalid shadow (underrun), keeping the captured sample for the next slot.
REQ-025 SHALL, when en=0, force on the next clk i2s_bclk, i2s_lrclk and i2s_sdata to 0, clear the divider, bit_cnt and the shift register, and block new pops.
REQ-026 SHALL, when en=0, let an in-flight POP/CAPTURE complete and retain the shadow sample.
REQ-027 SHALL, when en rises, restart at bit_cnt=0 with the divider at 0 and the first bclk rise after BCLK_DIV cycles.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force all outputs and underrun_cnt to 0, put the FSM in IDLE, clear the shadow flag, and clear the divider and bit_cnt.
REQ-029 SHALL, after rst_n rises with en=1, issue the first pop within 2 clk cycles when fifo_empty=0.

Verification
REQ-030 SHALL verify that, with defaults and a FIFO preloaded 0x001, 0x002, ..., the left slot carries 0x0010 and the right slot carries 0x0020 MSB-first with no underrun.
REQ-031 SHALL verify that each frame is 256 clk cycles long, i2s_lrclk is 0 for 16 bclk periods and 1 for 16, and each word-select edge precedes the MSB by one bclk.
REQ-032 SHALL verify that holding fifo_empty=1 gives i2s_sdata=0, underrun pulses of exactly 2 per frame and underrun_cnt=4 after 2 frames.
REQ-033 SHALL verify that forcing underrun_cnt to 16'hFFFE and running 3 further underruns leaves underrun_cnt at 16'hFFFF.
REQ-034 SHALL verify that dropping en mid-slot gives all I2S outputs 0 on the next cycle, completes any pop once, and on re-enable transmits the retained shadow sample in the first left slot.
REQ-035 SHALL verify that asserting rst_n=0 mid-frame with fifo_rd_en high clears all outputs immediately without waiting for clk, and that no pop occurs while in reset.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: pulls samples from an upstream FIFO through a one-deep shadow
// register and serializes them MSB-first into left/right slots with bclk/lrclk.
module i2s_tx #(
  parameter int DATA_WIDTH = 12,
  parameter int SLOT_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int PAD   = SLOT_WIDTH - DATA_WIDTH;
  localparam logic [DIV_W-1:0] DIV_MAX     = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] RIGHT_START = CNT_W'(SLOT_WIDTH);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE} fetch_state_t;

  fetch_state_t          state_reg;
  logic [DIV_W-1:0]      div_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [SLOT_WIDTH-1:0] shift_reg;
  logic [SLOT_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] shadow_reg;
  logic                  shadow_valid_reg;
  logic                  bclk_reg;
  logic                  lrclk_reg;
  logic                  sdata_reg;
  logic                  rd_en_reg;
  logic                  underrun_reg;
  logic [15:0]           underrun_cnt_reg;
  logic                  bit_event;
  logic                  slot_load;

  // Data changes on the falling bclk edge so the receiver samples on the rising one.
  assign bit_event    = en && bclk_reg && (div_reg == DIV_MAX);
  assign bit_cnt_next = (bit_cnt_reg == CNT_MAX) ? '0 : bit_cnt_reg + 1'b1;
  assign slot_load    = bit_event && ((bit_cnt_reg == '0) || (bit_cnt_reg == RIGHT_START));
  assign load_word    = SLOT_WIDTH'(shadow_reg) << PAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg          <= '0;
      bclk_reg         <= 1'b0;
      bit_cnt_reg      <= '0;
      lrclk_reg        <= 1'b0;
      shift_reg        <= '0;
      sdata_reg        <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else if (!en) begin
      div_reg      <= '0;
      bclk_reg     <= 1'b0;
      bit_cnt_reg  <= '0;
      lrclk_reg    <= 1'b0;
      shift_reg    <= '0;
      sdata_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (div_reg == DIV_MAX) begin
        div_reg  <= '0;
        bclk_reg <= ~bclk_reg;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
      if (bit_event) begin
        bit_cnt_reg <= bit_cnt_next;
        lrclk_reg   <= (bit_cnt_next >= RIGHT_START);
        if (slot_load) begin
          shift_reg    <= shadow_valid_reg ? load_word : '0;
          sdata_reg    <= shadow_valid_reg & load_word[SLOT_WIDTH-1];
          underrun_reg <= ~shadow_valid_reg;
          if (!shadow_valid_reg && (underrun_cnt_reg != 16'hFFFF))
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end else begin
          shift_reg <= {shift_reg[SLOT_WIDTH-2:0], 1'b0};
          sdata_reg <= shift_reg[SLOT_WIDTH-2];
        end
      end
    end
  end

  // Fetch runs independently of en once started so an in-flight pop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rd_en_reg        <= 1'b0;
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!shadow_valid_reg && !fifo_empty && en) begin
            state_reg <= POP;
            rd_en_reg <= 1'b1;
          end
        end
        POP: begin
          state_reg <= CAPTURE;
          rd_en_reg <= 1'b0;
        end
        CAPTURE: begin
          state_reg  <= IDLE;
          shadow_reg <= fifo_data;
        end
        default: begin
          state_reg <= IDLE;
          rd_en_reg <= 1'b0;
        end
      endcase
      if (state_reg == CAPTURE)
        shadow_valid_reg <= 1'b1;
      else if (slot_load)
        shadow_valid_reg <= 1'b0;
    end
  end

  assign fifo_rd_en   = rd_en_reg;
  assign i2s_bclk     = bclk_reg;
  assign i2s_lrclk    = lrclk_reg;
  assign i2s_sdata    = sdata_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a time-based model of the I2S waveform checked every cycle,
// plus a bit receiver and literal expectations for slot words, counts and resets.
module tb_i2s_tx;
  localparam int DW = 12;
  localparam int SW = 16;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;
  int cyc = 0;
  int pop_total = 0;
  int pop_base = 0;
  int fifo_level = 0;
  int rise_cnt = 0;
  int last_lr_rise = 0;
  int lr_period = 0;
  int ur_pulses = 0;
  int ur_base = 0;
  logic [15:0] rx_word = '0;
  logic rx_lr = 1'b0;
  logic prev_bclk = 1'b0;
  logic prev_lr = 1'b0;
  logic prev_rd = 1'b0;
  bit chk_on = 1'b0;
  logic [15:0] slot_word [0:63];
  logic        slot_ur   [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // FIFO that returns 1,2,3,... counted from pop_base, data one cycle after the pop.
  assign fifo_empty = (pop_total - pop_base) >= fifo_level;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= DW'(pop_total - pop_base + 1);
      pop_total <= pop_total + 1;
    end
    if (!rst_n || !en) k <= 0;
    else k <= k + 1;
    cyc <= cyc + 1;
  end

  task automatic set_slots(input int first_sample, input bit starve);
    for (int s = 0; s < 64; s++) begin
      slot_word[s] = starve ? 16'h0000 : 16'((first_sample + s) << (SW - DW));
      slot_ur[s]   = starve;
    end
  endtask

  // Expected {bclk, lrclk, sdata, underrun} after kk enabled clock edges.
  function automatic logic [3:0] model(input int kk);
    logic [3:0] r;
    logic [15:0] w;
    int b, s, p;
    r = '0;
    r[3] = ((kk / BD) % 2) == 1;
    b = kk / (2 * BD);
    r[2] = (b % (2 * SW)) >= SW;
    if (b > 0) begin
      s = (b - 1) / SW;
      p = SW - 1 - ((b - 1) % SW);
      if (s < 64) begin
        w = slot_word[s];
        r[1] = w[p];
        r[0] = ((kk % (2 * BD)) == 0) && (((b - 1) % SW) == 0) && slot_ur[s];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    if (chk_on) begin
      e = model(k);
      chk("bclk", i2s_bclk, e[3]);
      chk("lrclk", i2s_lrclk, e[2]);
      chk("sdata", i2s_sdata, e[1]);
      chk("underrun", underrun, e[0]);
      chk("rd_en_one_cycle", fifo_rd_en & prev_rd, 0);
      chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
    end
    if (k == 0) rise_cnt <= 0;
    if (i2s_bclk && !prev_bclk) begin
      rx_word  <= {rx_word[14:0], i2s_sdata};
      rx_lr    <= i2s_lrclk;
      rise_cnt <= rise_cnt + 1;
    end
    if (i2s_lrclk && !prev_lr) begin
      lr_period    <= cyc - last_lr_rise;
      last_lr_rise <= cyc;
    end
    if (underrun) ur_pulses <= ur_pulses + 1;
    prev_bclk <= i2s_bclk;
    prev_lr   <= i2s_lrclk;
    prev_rd   <= fifo_rd_en;
  end

  task automatic wait_k(input int target);
    int i = 0;
    while (k < target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("wait_k", k >= target, 1);
  endtask

  task automatic wait_rise(input int n);
    int i = 0;
    while (rise_cnt < n && i < 5000) begin
      @(posedge clk);
      i++;
    end
    chk("wait_rise", rise_cnt >= n, 1);
  endtask

  task automatic note(input string what, input logic [31:0] val);
    $display("t=%0t k=%0d %s = 0x%0h", $time, k, what, val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Normal streaming from a preloaded FIFO.
    pop_base = 0;
    fifo_level = 16;
    set_slots(1, 1'b0);
    en = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_outputs", {fifo_rd_en, i2s_bclk, i2s_lrclk, i2s_sdata, underrun}, 0);
    chk("reset_underrun_cnt", underrun_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_pop_after_reset", fifo_rd_en, 1);
    wait_rise(17);
    note("left word", rx_word);
    chk("left_slot_word", rx_word, 16'h0010);
    chk("ws_leads_left_lsb", rx_lr, 1);
    wait_rise(33);
    note("right word", rx_word);
    chk("right_slot_word", rx_word, 16'h0020);
    chk("ws_leads_right_lsb", rx_lr, 0);
    wait_k(400);
    chk("frame_clk_cycles", lr_period, 256);
    chk("no_underrun_streaming", underrun_cnt, 0);
    chk("pops_streaming", pop_total - pop_base, 5);

    // Starved FIFO: every slot underruns.
    @(negedge clk);
    #2 rst_n = 1'b0;
    pop_base = pop_total;
    fifo_level = 0;
    set_slots(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_k(512);
    note("underrun_cnt", underrun_cnt);
    chk("underrun_cnt_two_frames", underrun_cnt, 4);
    chk("pops_starved", pop_total - pop_base, 0);

    // Saturation of the underrun counter.
    force dut.underrun_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_cnt_reg;
    chk("underrun_cnt_preset", underrun_cnt, 16'hFFFE);
    ur_base = ur_pulses;
    wait_k(522);
    chk("underrun_cnt_reaches_max", underrun_cnt, 16'hFFFF);
    wait_k(780);
    note("underrun_cnt", underrun_cnt);
    chk("underrun_pulses_after_preset", ur_pulses - ur_base, 3);
    chk("underrun_cnt_saturated", underrun_cnt, 16'hFFFF);

    // Drop en with a pop in flight, then re-enable.
    @(negedge clk);
    #2 rst_n = 1'b0;
    pop_base = pop_total;
    fifo_level = 16;
    set_slots(1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_k(137);
    chk("pop_in_flight_at_disable", fifo_rd_en, 1);
    en = 1'b0;
    @(negedge clk);
    chk("disable_outputs_zero", {i2s_bclk, i2s_lrclk, i2s_sdata}, 0);
    chk("disable_pop_strobe_ends", fifo_rd_en, 0);
    repeat (20) @(negedge clk);
    chk("pops_while_disabled", pop_total - pop_base, 3);
    set_slots(3, 1'b0);
    en = 1'b1;
    wait_rise(17);
    note("left word after re-enable", rx_word);
    chk("retained_sample_left", rx_word, 16'h0030);

    // Asynchronous reset while a pop strobe is high.
    wait_k(137);
    chk("pop_strobe_before_reset", fifo_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {fifo_rd_en, i2s_bclk, i2s_lrclk, i2s_sdata, underrun}, 0);
    chk("async_reset_underrun_cnt", underrun_cnt, 0);
    repeat (20) @(negedge clk);
    chk("no_pop_in_reset", pop_total - pop_base, 4);
    chk("rd_en_low_in_reset", fifo_rd_en, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
